hazard_unit_r1: RTL and testbench

Parametrised successor to data_forwarding_unit_r0. It merges operand forwarding, load-use and branch-operand stall detection, control-flow flush and multi-cycle EX-op interlock into one pipeline control block for the 5-stage datapath. It sits beside the pipeline registers, drives the forwarding muxes and the en_n/flush controls of the PC, IF/ID, ID/EX and EX/MEM delay stages, and keeps a performance stall counter.

---
 rtl/hazard_unit_r1_pkg.sv | 20 ++
 rtl/fwd_match_r1.sv | 57 +++++
 rtl/hazard_unit_r1.sv | 147 ++++++++++++++
 tb/tb_hazard_unit_r1.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_r1_pkg.sv
// Shared definitions for the pipeline hazard unit: forward-mux select codes,
// multi-cycle tracker states and the default register address width.
package hazard_unit_r1_pkg;

    localparam int REG_ADDR_WIDTH_DEF = 5;

    // Forwarding mux select, one per EX read port.
    typedef enum logic [1:0] {
        FWD_REG = 2'd0,   // operand from register file
        FWD_MEM = 2'd1,   // operand from MEM-stage ALU result
        FWD_WB  = 2'd2    // operand from WB-stage result
    } fwd_sel_e;

    // Multi-cycle EX op tracker.
    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

endpackage

// File: rtl/fwd_match_r1.sv
// Per-read-port comparator. For the EX-stage source it picks the forwarding
// source (MEM beats WB, r0 is never forwarded). For the ID-stage source it
// reports whether the operand is still being produced by EX or by a MEM load,
// which the top uses for load-use and branch-operand stalls.
module fwd_match_r1
    import hazard_unit_r1_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
    input  logic [REG_ADDR_WIDTH-1:0] ex_src_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_src_i,
    input  logic                      id_used_i,
    input  logic                      ex_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_dst_i,
    input  logic                      mem_we_i,
    input  logic                      mem_load_i,
    input  logic [REG_ADDR_WIDTH-1:0] mem_dst_i,
    input  logic                      wb_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_dst_i,
    output logic [1:0]                fwd_sel_o,
    output logic                      id_hit_ex_o,
    output logic                      id_hit_mem_load_o
);

    // A stage supplies a register only if it writes it and it is not r0.
    function automatic logic dst_hit(input logic                      we,
                                     input logic [REG_ADDR_WIDTH-1:0] dst,
                                     input logic [REG_ADDR_WIDTH-1:0] src);
        return we && (dst != {REG_ADDR_WIDTH{1'b0}}) && (dst == src);
    endfunction

    // Priority-encode the forwarding source for the EX operand.
    always_comb begin
        fwd_sel_o = FWD_REG;
        if (dst_hit(mem_we_i, mem_dst_i, ex_src_i)) begin
            fwd_sel_o = FWD_MEM;
        end else if (dst_hit(wb_we_i, wb_dst_i, ex_src_i)) begin
            fwd_sel_o = FWD_WB;
        end else begin
            fwd_sel_o = FWD_REG;
        end
    end

    // Flag ID operands that are not yet available from EX or a MEM load.
    always_comb begin
        id_hit_ex_o       = 1'b0;
        id_hit_mem_load_o = 1'b0;
        if (id_used_i) begin
            id_hit_ex_o       = dst_hit(ex_we_i, ex_dst_i, id_src_i);
            id_hit_mem_load_o = mem_load_i && dst_hit(mem_we_i, mem_dst_i, id_src_i);
        end else begin
            id_hit_ex_o       = 1'b0;
            id_hit_mem_load_o = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_unit_r1.sv
// Pipeline control for the 5-stage datapath: operand forwarding, load-use and
// branch-operand stalls, control-flow flush, multi-cycle EX interlock and a
// saturating stall-cycle counter.
module hazard_unit_r1
    import hazard_unit_r1_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int NUM_RD         = 2,
    parameter int MC_LAT         = 4,
    parameter int MC_CNT_WIDTH   = 3,
    parameter int STAT_WIDTH     = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_RD*REG_ADDR_WIDTH-1:0] id_rr,
    input  logic [NUM_RD-1:0]                id_rr_used,
    input  logic                             id_branch,
    input  logic                             id_redirect,
    input  logic [NUM_RD*REG_ADDR_WIDTH-1:0] ex_rr,
    input  logic                             ex_regWrite,
    input  logic                             ex_memRead,
    input  logic [REG_ADDR_WIDTH-1:0]        ex_regToWrite,
    input  logic                             ex_mc_start,
    input  logic                             mem_regWrite,
    input  logic                             mem_memRead,
    input  logic [REG_ADDR_WIDTH-1:0]        mem_regToWrite,
    input  logic                             wb_regWrite,
    input  logic [REG_ADDR_WIDTH-1:0]        wb_regToWrite,
    output logic [2*NUM_RD-1:0]              forward,
    output logic                             pc_hold,
    output logic                             ifid_hold,
    output logic                             idex_bubble,
    output logic                             exmem_hold,
    output logic                             ifid_flush,
    output logic                             mc_busy,
    output logic                             mc_done,
    output logic [STAT_WIDTH-1:0]            stall_cycles
);

    localparam logic [MC_CNT_WIDTH-1:0] MC_LOAD = MC_CNT_WIDTH'(MC_LAT - 1);
    localparam logic [MC_CNT_WIDTH-1:0] MC_ONE  = {{(MC_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [MC_CNT_WIDTH-1:0] MC_ZERO = {MC_CNT_WIDTH{1'b0}};
    localparam logic [STAT_WIDTH-1:0]   ST_ONE  = {{(STAT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [STAT_WIDTH-1:0]   ST_MAX  = {STAT_WIDTH{1'b1}};

    mc_state_e                 state_q, state_d;
    logic [MC_CNT_WIDTH-1:0]   mc_cnt_q, mc_cnt_d;
    logic [STAT_WIDTH-1:0]     stall_q, stall_d;

    logic [NUM_RD-1:0]         id_hit_ex_s;
    logic [NUM_RD-1:0]         id_hit_mem_ld_s;
    logic                      lu_stall_s;
    logic                      br_stall_s;
    logic                      mc_stall_s;

    // One comparator per read port serves both EX forwarding and ID stall checks.
    for (genvar g = 0; g < NUM_RD; g++) begin : g_port
        fwd_match_r1 #(
            .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
        ) u_match (
            .ex_src_i          (ex_rr[g*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
            .id_src_i          (id_rr[g*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
            .id_used_i         (id_rr_used[g]),
            .ex_we_i           (ex_regWrite),
            .ex_dst_i          (ex_regToWrite),
            .mem_we_i          (mem_regWrite),
            .mem_load_i        (mem_memRead),
            .mem_dst_i         (mem_regToWrite),
            .wb_we_i           (wb_regWrite),
            .wb_dst_i          (wb_regToWrite),
            .fwd_sel_o         (forward[2*g +: 2]),
            .id_hit_ex_o       (id_hit_ex_s[g]),
            .id_hit_mem_load_o (id_hit_mem_ld_s[g])
        );
    end

    // Multi-cycle tracker next state; a start while busy is ignored.
    always_comb begin
        state_d  = state_q;
        mc_cnt_d = mc_cnt_q;
        case (state_q)
            MC_IDLE: begin
                if (ex_mc_start) begin
                    state_d  = MC_BUSY;
                    mc_cnt_d = MC_LOAD;
                end else begin
                    state_d  = MC_IDLE;
                    mc_cnt_d = MC_ZERO;
                end
            end
            MC_BUSY: begin
                if (mc_cnt_q <= MC_ONE) begin
                    state_d  = MC_IDLE;
                    mc_cnt_d = MC_ZERO;
                end else begin
                    state_d  = MC_BUSY;
                    mc_cnt_d = mc_cnt_q - MC_ONE;
                end
            end
            default: begin
                state_d  = MC_IDLE;
                mc_cnt_d = MC_ZERO;
            end
        endcase
    end

    // Stall, bubble, hold and flush decode.
    always_comb begin
        lu_stall_s  = ex_memRead && (|id_hit_ex_s);
        br_stall_s  = id_branch && ((|id_hit_ex_s) || (|id_hit_mem_ld_s));
        mc_busy     = (state_q == MC_BUSY);
        mc_done     = mc_busy && (mc_cnt_q == MC_ONE);
        mc_stall_s  = mc_busy || ((state_q == MC_IDLE) && ex_mc_start);
        pc_hold     = lu_stall_s || br_stall_s || mc_stall_s;
        ifid_hold   = pc_hold;
        idex_bubble = (lu_stall_s || br_stall_s) && !mc_stall_s;
        exmem_hold  = mc_stall_s && !mc_done;
        // A stall outranks a redirect; the redirect is seen again next cycle.
        ifid_flush  = id_redirect && !pc_hold;
    end

    // Saturating count of cycles in which the PC was held.
    always_comb begin
        stall_d = stall_q;
        if (pc_hold && (stall_q != ST_MAX)) begin
            stall_d = stall_q + ST_ONE;
        end else begin
            stall_d = stall_q;
        end
    end

    // State registers with synchronous reset; reset aborts any multi-cycle op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MC_IDLE;
            mc_cnt_q <= MC_ZERO;
            stall_q  <= {STAT_WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
            stall_q  <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_unit_r1.sv
// Scoreboard bench for hazard_unit_r1: a driver applies directed and random
// vectors and queues the reference-model expectation; a monitor on the falling
// edge pops and compares every output.
module tb_hazard_unit_r1;

    localparam int AW  = 5;
    localparam int NR  = 2;
    localparam int LAT = 4;
    localparam int SW  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR*AW-1:0] id_rr, ex_rr;
    logic [NR-1:0]   id_rr_used;
    logic            id_branch, id_redirect;
    logic            ex_regWrite, ex_memRead, ex_mc_start;
    logic [AW-1:0]   ex_regToWrite;
    logic            mem_regWrite, mem_memRead;
    logic [AW-1:0]   mem_regToWrite;
    logic            wb_regWrite;
    logic [AW-1:0]   wb_regToWrite;
    logic [2*NR-1:0] forward;
    logic            pc_hold, ifid_hold, idex_bubble, exmem_hold, ifid_flush;
    logic            mc_busy, mc_done;
    logic [SW-1:0]   stall_cycles;

    hazard_unit_r1 #(
        .REG_ADDR_WIDTH (AW),
        .NUM_RD         (NR),
        .MC_LAT         (LAT),
        .MC_CNT_WIDTH   (3),
        .STAT_WIDTH     (SW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rr          (id_rr),
        .id_rr_used     (id_rr_used),
        .id_branch      (id_branch),
        .id_redirect    (id_redirect),
        .ex_rr          (ex_rr),
        .ex_regWrite    (ex_regWrite),
        .ex_memRead     (ex_memRead),
        .ex_regToWrite  (ex_regToWrite),
        .ex_mc_start    (ex_mc_start),
        .mem_regWrite   (mem_regWrite),
        .mem_memRead    (mem_memRead),
        .mem_regToWrite (mem_regToWrite),
        .wb_regWrite    (wb_regWrite),
        .wb_regToWrite  (wb_regToWrite),
        .forward        (forward),
        .pc_hold        (pc_hold),
        .ifid_hold      (ifid_hold),
        .idex_bubble    (idex_bubble),
        .exmem_hold     (exmem_hold),
        .ifid_flush     (ifid_flush),
        .mc_busy        (mc_busy),
        .mc_done        (mc_done),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fwd;
        int pc, ifid, bub, exh, flush, busy, done, sc;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: remaining busy cycles of the current
    // multi-cycle op, and the number of held cycles so far.
    int   m_busy_left = 0;
    int   m_stalls = 0;

    task automatic chk(input string nm, input int act, input int req);
        if (act != req) begin
            miscompares++;
            $display("FAIL %s vec=%0d got=%0d expected=%0d", nm, vectors, act, req);
        end
    endtask

    // Monitor: compare every queued expectation against the live outputs.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            vectors++;
            chk("forward",      int'(forward),      e.fwd);
            chk("pc_hold",      int'(pc_hold),      e.pc);
            chk("ifid_hold",    int'(ifid_hold),    e.ifid);
            chk("idex_bubble",  int'(idex_bubble),  e.bub);
            chk("exmem_hold",   int'(exmem_hold),   e.exh);
            chk("ifid_flush",   int'(ifid_flush),   e.flush);
            chk("mc_busy",      int'(mc_busy),      e.busy);
            chk("mc_done",      int'(mc_done),      e.done);
            chk("stall_cycles", int'(stall_cycles), e.sc);
        end
    end

    function automatic int reg_of(input logic [NR*AW-1:0] v, input int p);
        return int'(v[p*AW +: AW]);
    endfunction

    // Does a stage that writes 'we'/'dst' supply register 'src'?
    function automatic bit supplies(input logic we, input int dst, input int src);
        return (we == 1'b1) && (dst != 0) && (dst == src);
    endfunction

    // Compute the expected outputs for the inputs now applied, queue them,
    // then advance the model across the coming clock edge.
    task automatic push_exp();
        exp_t e;
        bit lu, br, busy, mcs;
        int sel;
        e.fwd = 0;
        for (int p = 0; p < NR; p++) begin
            sel = 0;
            if (supplies(mem_regWrite, int'(mem_regToWrite), reg_of(ex_rr, p)))
                sel = 1;
            else if (supplies(wb_regWrite, int'(wb_regToWrite), reg_of(ex_rr, p)))
                sel = 2;
            e.fwd += sel << (2 * p);
        end
        lu = 0;
        br = 0;
        for (int p = 0; p < NR; p++) begin
            if (id_rr_used[p]) begin
                bit in_ex, in_mem_load;
                in_ex       = supplies(ex_regWrite, int'(ex_regToWrite), reg_of(id_rr, p));
                in_mem_load = mem_memRead &&
                              supplies(mem_regWrite, int'(mem_regToWrite), reg_of(id_rr, p));
                if (ex_memRead && in_ex) lu = 1;
                if (id_branch && (in_ex || in_mem_load)) br = 1;
            end
        end
        busy    = (m_busy_left > 0);
        mcs     = busy || ex_mc_start;
        e.busy  = int'(busy);
        e.done  = int'(m_busy_left == 1);
        e.pc    = int'(lu || br || mcs);
        e.ifid  = e.pc;
        e.bub   = int'((lu || br) && !mcs);
        e.exh   = int'(mcs && (e.done == 0));
        e.flush = int'(id_redirect && (e.pc == 0));
        e.sc    = m_stalls;
        sb_q.push_back(e);
        if (rst) begin
            m_busy_left = 0;
            m_stalls    = 0;
        end else begin
            if (busy) m_busy_left = m_busy_left - 1;
            else if (ex_mc_start) m_busy_left = LAT - 1;
            if (e.pc == 1 && m_stalls < (1 << SW) - 1) m_stalls++;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        rst = 1'b0;
        id_rr = '0; id_rr_used = '0; id_branch = 1'b0; id_redirect = 1'b0;
        ex_rr = '0; ex_regWrite = 1'b0; ex_memRead = 1'b0; ex_regToWrite = '0;
        ex_mc_start = 1'b0;
        mem_regWrite = 1'b0; mem_memRead = 1'b0; mem_regToWrite = '0;
        wb_regWrite = 1'b0; wb_regToWrite = '0;
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state with zero inputs: all outputs zero.
        rst = 1'b1; push_exp();

        // Forwarding: MEM over WB, then WB alone, then r0 never forwarded.
        cyc(); idle_in();
        mem_regWrite = 1'b1; mem_regToWrite = 5'd5;
        wb_regWrite = 1'b1; wb_regToWrite = 5'd5; ex_rr = 10'd5; push_exp();
        cyc(); mem_regWrite = 1'b0; push_exp();
        cyc(); mem_regWrite = 1'b1; mem_regToWrite = 5'd0; wb_regToWrite = 5'd0;
        ex_rr = 10'd0; push_exp();

        // Load-use on port 1: one held cycle, then the load has moved on.
        cyc(); idle_in();
        ex_memRead = 1'b1; ex_regWrite = 1'b1; ex_regToWrite = 5'd3;
        id_rr = {5'd3, 5'd0}; id_rr_used = 2'b10; push_exp();
        cyc(); ex_memRead = 1'b0; ex_regWrite = 1'b0; ex_regToWrite = 5'd0; push_exp();

        // Load feeding a taken branch: two stalls, then the flush.
        cyc(); idle_in();
        ex_memRead = 1'b1; ex_regWrite = 1'b1; ex_regToWrite = 5'd4;
        id_branch = 1'b1; id_redirect = 1'b1; id_rr = {5'd0, 5'd4}; id_rr_used = 2'b01;
        push_exp();
        cyc(); ex_memRead = 1'b0; ex_regWrite = 1'b0; ex_regToWrite = 5'd0;
        mem_memRead = 1'b1; mem_regWrite = 1'b1; mem_regToWrite = 5'd4; push_exp();
        cyc(); mem_memRead = 1'b0; mem_regWrite = 1'b0; mem_regToWrite = 5'd0;
        wb_regWrite = 1'b1; wb_regToWrite = 5'd4; push_exp();

        // Multi-cycle op with a second start mid-op that must be ignored.
        cyc(); idle_in(); ex_mc_start = 1'b1; push_exp();
        cyc(); ex_mc_start = 1'b0; push_exp();
        cyc(); ex_mc_start = 1'b1; push_exp();
        cyc(); ex_mc_start = 1'b0; push_exp();
        cyc(); push_exp();

        // Reset in the middle of a multi-cycle op aborts it.
        cyc(); ex_mc_start = 1'b1; push_exp();
        cyc(); ex_mc_start = 1'b0; push_exp();
        cyc(); rst = 1'b1; push_exp();
        for (int k = 0; k < 4; k++) begin
            cyc(); idle_in(); push_exp();
        end

        // Twenty back-to-back stall cycles saturate the counter.
        for (int k = 0; k < 20; k++) begin
            cyc(); idle_in(); ex_mc_start = 1'b1; push_exp();
        end
        for (int k = 0; k < 5; k++) begin
            cyc(); idle_in(); push_exp();
        end

        // Random traffic over a small register range so hazards are frequent.
        for (int n = 0; n < 400; n++) begin
            cyc();
            rst = ($urandom_range(0, 49) == 0);
            for (int p = 0; p < NR; p++) begin
                id_rr[p*AW +: AW] = AW'($urandom_range(0, 3));
                ex_rr[p*AW +: AW] = AW'($urandom_range(0, 3));
            end
            id_rr_used     = NR'($urandom_range(0, 3));
            id_branch      = ($urandom_range(0, 3) == 0);
            id_redirect    = ($urandom_range(0, 3) == 0);
            ex_regWrite    = 1'($urandom_range(0, 1));
            ex_memRead     = ($urandom_range(0, 2) == 0);
            ex_regToWrite  = AW'($urandom_range(0, 3));
            ex_mc_start    = ($urandom_range(0, 9) == 0);
            mem_regWrite   = 1'($urandom_range(0, 1));
            mem_memRead    = ($urandom_range(0, 2) == 0);
            mem_regToWrite = AW'($urandom_range(0, 3));
            wb_regWrite    = 1'($urandom_range(0, 1));
            wb_regToWrite  = AW'($urandom_range(0, 3));
            push_exp();
        end

        cyc(); idle_in();
        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got=%0d pending expected=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
